// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: ALU/muldiv opcodes, ID/EX and EX/MEM pipeline registers.
// Also holds the small helpers used by the iterative multiply/divide unit.
package ex_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_t;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        alu_op_t    alu_op;
        md_op_t     md_op;
        logic       is_md;
        logic [4:0] inst_rd;
        mem_ctrl_t  mem_ctrl;
        wb_ctrl_t   wb_ctrl;
        logic       valid;
    } id_ex_regs_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] read_data2;
        logic [4:0]      inst_rd;
        mem_ctrl_t       mem_ctrl;
        wb_ctrl_t        wb_ctrl;
    } ex_mem_regs_t;

    localparam ex_mem_regs_t EX_MEM_BUBBLE = '0;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic md_is_rem(input md_op_t op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundles the execute-stage pipeline inputs/outputs; master drives ID/EX side, slave is the stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    id_ex_regs_t     i_id_ex_regs;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic [XLEN-1:0] i_rs2_data;
    logic            i_flush;
    logic            o_busy;
    ex_mem_regs_t    o_ex_mem_regs;

    modport master (output i_id_ex_regs, i_op_a, i_op_b, i_rs2_data, i_flush,
                    input  o_busy, o_ex_mem_regs);
    modport slave  (input  i_id_ex_regs, i_op_a, i_op_b, i_rs2_data, i_flush,
                    output o_busy, o_ex_mem_regs);
endinterface

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative radix-2 RV32M unit: shift-add multiply, restoring divide, sign fix-up on magnitudes.
// Divide-by-zero and signed overflow skip the iteration loop and go straight to DONE.
module muldiv_unit
    import ex_stage_pkg::*;
#(
    parameter int MD_ITERS = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  md_op_t      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_kill,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    md_state_t   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    md_op_t      op_q, op_d;
    logic [31:0] mag_q, mag_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic        special_q, special_d;
    logic [31:0] special_res_q, special_res_d;

    logic        div_s, a_signed_s, b_signed_s, div_zero_s, div_ovf_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [32:0] add_s, rem_shift_s, sub_s;
    logic [63:0] step_s, prod_s;
    logic [31:0] quot_s, rem_s;

    // Operand decode at issue time.
    always_comb begin
        div_s      = md_is_div(i_op);
        a_signed_s = (i_op == MD_MULH) || (i_op == MD_MULHSU) || (i_op == MD_DIV) || (i_op == MD_REM);
        b_signed_s = (i_op == MD_MULH) || (i_op == MD_DIV) || (i_op == MD_REM);
        a_mag_s    = abs_val(i_a, a_signed_s);
        b_mag_s    = abs_val(i_b, b_signed_s);
        div_zero_s = div_s && (i_b == 32'd0);
        div_ovf_s  = ((i_op == MD_DIV) || (i_op == MD_REM)) &&
                     (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    end

    // One iteration: acc holds {hi, multiplier} for multiply, {remainder, quotient} for divide.
    always_comb begin
        add_s       = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag_q : 32'd0)};
        rem_shift_s = acc_q[63:31];
        sub_s       = rem_shift_s - {1'b0, mag_q};
        if (!md_is_div(op_q)) begin
            step_s = {add_s, acc_q[31:1]};
        end else if (sub_s[32]) begin
            step_s = {rem_shift_s[31:0], acc_q[30:0], 1'b0};
        end else begin
            step_s = {sub_s[31:0], acc_q[30:0], 1'b1};
        end
    end

    // Sign fix-up and result select.
    always_comb begin
        prod_s = neg_q ? (~acc_q + 64'd1) : acc_q;
        quot_s = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_s  = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (special_q) begin
            o_result = special_res_q;
        end else begin
            case (op_q)
                MD_MUL:                       o_result = prod_s[31:0];
                MD_MULH, MD_MULHSU, MD_MULHU: o_result = prod_s[63:32];
                MD_DIV, MD_DIVU:              o_result = quot_s;
                default:                      o_result = rem_s;
            endcase
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        mag_d         = mag_q;
        acc_d         = acc_q;
        neg_d         = neg_q;
        special_d     = special_q;
        special_res_d = special_res_q;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (i_start) begin
                    o_busy    = 1'b1;
                    op_d      = i_op;
                    cnt_d     = 6'd0;
                    neg_d     = md_is_rem(i_op) ? (a_signed_s && i_a[31])
                                                : ((a_signed_s && i_a[31]) ^ (b_signed_s && i_b[31]));
                    acc_d     = div_s ? {32'd0, a_mag_s} : {32'd0, b_mag_s};
                    mag_d     = div_s ? b_mag_s : a_mag_s;
                    special_d = div_zero_s || div_ovf_s;
                    if (div_zero_s) begin
                        special_res_d = md_is_rem(i_op) ? i_a : 32'hFFFF_FFFF;
                    end else begin
                        special_res_d = md_is_rem(i_op) ? 32'd0 : 32'h8000_0000;
                    end
                    state_d   = (div_zero_s || div_ovf_s) ? MD_DONE : MD_BUSY;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                o_busy = 1'b1;
                acc_d  = step_s;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'(MD_ITERS - 1)) begin
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            MD_DONE: begin
                o_done  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (i_kill) begin
            state_d = MD_IDLE;
            o_busy  = 1'b0;
            o_done  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= MD_IDLE;
            cnt_q         <= 6'd0;
            op_q          <= MD_MUL;
            mag_q         <= 32'd0;
            acc_q         <= 64'd0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            mag_q         <= mag_d;
            acc_q         <= acc_d;
            neg_q         <= neg_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative muldiv, feeding the registered EX/MEM pipeline register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MD_ITERS = 32
) (
    input  logic    i_clk,
    input  logic    i_rst,
    ex_stage_if.slave bus
);

    id_ex_regs_t  idex_s;
    logic [31:0]  alu_res_s;
    logic [4:0]   shamt_s;
    logic         md_busy_s, md_done_s;
    logic [31:0]  md_result_s;
    ex_mem_regs_t ex_mem_q, ex_mem_d;

    assign idex_s  = bus.i_id_ex_regs;
    assign shamt_s = bus.i_op_b[4:0];

    muldiv_unit #(.MD_ITERS(MD_ITERS)) u_muldiv (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (idex_s.valid && idex_s.is_md),
        .i_op     (idex_s.md_op),
        .i_a      (bus.i_op_a),
        .i_b      (bus.i_op_b),
        .i_kill   (bus.i_flush || i_rst),
        .o_busy   (md_busy_s),
        .o_done   (md_done_s),
        .o_result (md_result_s)
    );

    // Single-cycle ALU.
    always_comb begin
        alu_res_s = 32'd0;
        case (idex_s.alu_op)
            ALU_ADD:    alu_res_s = bus.i_op_a + bus.i_op_b;
            ALU_SUB:    alu_res_s = bus.i_op_a - bus.i_op_b;
            ALU_SLL:    alu_res_s = bus.i_op_a << shamt_s;
            ALU_SLT:    alu_res_s = ($signed(bus.i_op_a) < $signed(bus.i_op_b)) ? 32'd1 : 32'd0;
            ALU_SLTU:   alu_res_s = (bus.i_op_a < bus.i_op_b) ? 32'd1 : 32'd0;
            ALU_XOR:    alu_res_s = bus.i_op_a ^ bus.i_op_b;
            ALU_SRL:    alu_res_s = bus.i_op_a >> shamt_s;
            ALU_SRA:    alu_res_s = $unsigned($signed(bus.i_op_a) >>> shamt_s);
            ALU_OR:     alu_res_s = bus.i_op_a | bus.i_op_b;
            ALU_AND:    alu_res_s = bus.i_op_a & bus.i_op_b;
            ALU_PASS_B: alu_res_s = bus.i_op_b;
            default:    alu_res_s = 32'd0;
        endcase
    end

    // EX/MEM next value: flush wins, then a finished M op, then a plain ALU op; anything else bubbles.
    always_comb begin
        ex_mem_d = EX_MEM_BUBBLE;
        if (bus.i_flush) begin
            ex_mem_d = EX_MEM_BUBBLE;
        end else if (md_done_s || (idex_s.valid && !idex_s.is_md)) begin
            ex_mem_d.alu_out    = md_done_s ? md_result_s : alu_res_s;
            ex_mem_d.read_data2 = bus.i_rs2_data;
            ex_mem_d.inst_rd    = idex_s.inst_rd;
            ex_mem_d.mem_ctrl   = idex_s.mem_ctrl;
            ex_mem_d.wb_ctrl    = idex_s.wb_ctrl;
        end else begin
            ex_mem_d = EX_MEM_BUBBLE;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_mem_q <= EX_MEM_BUBBLE;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign bus.o_ex_mem_regs = ex_mem_q;
    assign bus.o_busy        = md_busy_s;

endmodule
